venus_mem_arbiter: RTL and testbench

- Shares one single-port synchronous data/instruction memory between two requesters: instruction fetch (IF port) and the execute-stage load/store unit (LS port).
- Sits between the fetch and execute stages and the memory macro.
- Grants are combinational within the request cycle; read data returns one cycle later.
- Generates per-port stall signals and applies a starvation guard so fetch is never locked out by continuous load/store traffic.

---
 rtl/venus_mem_arbiter.sv | 99 +++++++++
 tb/tb_venus_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/venus_mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory between fetch and load/store.
// Ports: clk, reset (async active-low), if_* fetch port, ls_* load/store port, mem_* macro side.
module venus_mem_arbiter #(
  parameter int ADDR     = 16,
  parameter int W_DATA   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_stall_o,
  output logic              if_rvalid_o,
  output logic [W_DATA-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_write_i,
  input  logic [ADDR-1:0]   ls_addr_i,
  input  logic [W_DATA-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_stall_o,
  output logic              ls_rvalid_o,
  output logic [W_DATA-1:0] ls_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR-1:0]   mem_addr_o,
  output logic [W_DATA-1:0] mem_wdata_o,
  input  logic [W_DATA-1:0] mem_rdata_i
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] starve_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       fetch_pri;
  logic       rd_gnt;

  assign fetch_pri = (starve_cnt == WAIT_MAX);

  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (fetch_pri) begin
      if_gnt_o = if_req_i;
      ls_gnt_o = ls_req_i & ~if_req_i;
    end else begin
      ls_gnt_o = ls_req_i;
      if_gnt_o = if_req_i & ~ls_req_i;
    end
  end

  assign if_stall_o = if_req_i & ~if_gnt_o;
  assign ls_stall_o = ls_req_i & ~ls_gnt_o;

  assign mem_en_o    = if_gnt_o | ls_gnt_o;
  assign mem_we_o    = ls_gnt_o & ls_write_i;
  assign mem_wdata_o = ls_wdata_i;

  always_comb begin
    mem_addr_o = '0;
    unique case (1'b1)
      if_gnt_o: mem_addr_o = if_addr_i;
      ls_gnt_o: mem_addr_o = ls_addr_i;
      default:  mem_addr_o = '0;
    endcase
  end

  // Stores complete in the grant cycle; only reads expect a return.
  assign rd_gnt = if_gnt_o | (ls_gnt_o & ~ls_write_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (if_req_i & ~if_gnt_o) begin
      if (starve_cnt != WAIT_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= rd_gnt;
      if (rd_gnt)
        rd_owner <= ls_gnt_o;
    end
  end

  assign if_rvalid_o = rd_pend & ~rd_owner;
  assign ls_rvalid_o = rd_pend & rd_owner;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_venus_mem_arbiter.sv
// Directed self-checking bench for venus_mem_arbiter.
// Inputs change on negedge; outputs sampled #1 later or on the following negedge.
module tb_venus_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_i;
  logic [15:0] if_addr_i;
  logic        if_gnt_o, if_stall_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_write_i;
  logic [15:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o, ls_stall_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  venus_mem_arbiter #(.ADDR(16), .W_DATA(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_stall_o(if_stall_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_write_i(ls_write_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_stall_o(ls_stall_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  task automatic idle();
    @(negedge clk);
    if_req_i = 0; if_addr_i = '0;
    ls_req_i = 0; ls_write_i = 0; ls_addr_i = '0; ls_wdata_i = '0;
    mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    if_req_i = 0; if_addr_i = '0;
    ls_req_i = 0; ls_write_i = 0; ls_addr_i = '0; ls_wdata_i = '0;
    mem_rdata_i = '0;
    #12;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid got %b exp 00", {if_rvalid_o, ls_rvalid_o});
    end
    checks++;
    if ({if_gnt_o, ls_gnt_o, mem_en_o, mem_we_o, mem_addr_o} !== 20'h0) begin
      errors++; $display("FAIL reset_idle got gnt=%b%b en=%b we=%b addr=%h exp 0",
        if_gnt_o, ls_gnt_o, mem_en_o, mem_we_o, mem_addr_o);
    end
    @(negedge clk); reset = 1;
    idle();
  endtask

  task automatic test_fetch_read();
    @(negedge clk);
    if_req_i = 1; if_addr_i = 16'h0010;
    #1;
    checks++;
    if ({if_gnt_o, if_stall_o, ls_gnt_o, mem_en_o, mem_we_o, mem_addr_o} !== {5'b10010, 16'h0010}) begin
      errors++; $display("FAIL fetch_grant got gnt=%b stall=%b en=%b addr=%h exp gnt=1 en=1 addr=0010",
        if_gnt_o, if_stall_o, mem_en_o, mem_addr_o);
    end
    @(negedge clk);
    if_req_i = 0; mem_rdata_i = 32'h12345678;
    #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o, if_rdata_o} !== {2'b10, 32'h12345678}) begin
      errors++; $display("FAIL fetch_rvalid got if=%b ls=%b data=%h exp 1 0 12345678",
        if_rvalid_o, ls_rvalid_o, if_rdata_o);
    end
    idle();
  endtask

  task automatic test_conflict();
    @(negedge clk);
    if_req_i = 1; if_addr_i = 16'h0004;
    ls_req_i = 1; ls_write_i = 0; ls_addr_i = 16'h0100;
    #1;
    checks++;
    if ({ls_gnt_o, if_gnt_o, if_stall_o, ls_stall_o, mem_addr_o} !== {4'b1010, 16'h0100}) begin
      errors++; $display("FAIL conflict_grant got ls=%b if=%b ifst=%b lsst=%b addr=%h exp 1 0 1 0 0100",
        ls_gnt_o, if_gnt_o, if_stall_o, ls_stall_o, mem_addr_o);
    end
    @(negedge clk);
    if_req_i = 0; ls_req_i = 0; mem_rdata_i = 32'hCAFE0100;
    #1;
    checks++;
    if ({ls_rvalid_o, if_rvalid_o, ls_rdata_o} !== {2'b10, 32'hCAFE0100}) begin
      errors++; $display("FAIL conflict_rvalid got ls=%b if=%b data=%h exp 1 0 cafe0100",
        ls_rvalid_o, if_rvalid_o, ls_rdata_o);
    end
    checks++;
    if (dut.starve_cnt !== 4'd1) begin
      errors++; $display("FAIL conflict_starve got %0d exp 1", dut.starve_cnt);
    end
    idle();
  endtask

  task automatic test_starvation();
    logic exp_if;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if_req_i = 1; if_addr_i = 16'h0200;
      ls_req_i = 1; ls_write_i = 0; ls_addr_i = 16'h0300;
      #1;
      exp_if = (i == 4);
      checks++;
      if ({if_gnt_o, ls_gnt_o, ls_stall_o, if_stall_o} !== {exp_if, ~exp_if, exp_if, ~exp_if}) begin
        errors++; $display("FAIL starve_cycle%0d got if=%b ls=%b lsst=%b ifst=%b exp if=%b",
          i, if_gnt_o, ls_gnt_o, ls_stall_o, if_stall_o, exp_if);
      end
      if (i == 4) begin
        @(posedge clk); #1;
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
          errors++; $display("FAIL starve_clear got %0d exp 0", dut.starve_cnt);
        end
      end
    end
    idle();
  endtask

  task automatic test_store();
    @(negedge clk);
    ls_req_i = 1; ls_write_i = 1; ls_addr_i = 16'h0020; ls_wdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if ({ls_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {3'b111, 16'h0020, 32'hDEADBEEF}) begin
      errors++; $display("FAIL store_drive got gnt=%b en=%b we=%b addr=%h wd=%h exp 1 1 1 0020 deadbeef",
        ls_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk);
    ls_req_i = 0; ls_write_i = 0;
    #1;
    checks++;
    if ({ls_rvalid_o, if_rvalid_o} !== 2'b00) begin
      errors++; $display("FAIL store_noresp got ls=%b if=%b exp 0 0", ls_rvalid_o, if_rvalid_o);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req_i = 1; if_addr_i = 16'h0030;
    ls_req_i = 1; ls_addr_i = 16'h0034;
    @(negedge clk);
    checks++;
    if (dut.starve_cnt !== 4'd1) begin
      errors++; $display("FAIL rmid_pre_starve got %0d exp 1", dut.starve_cnt);
    end
    ls_req_i = 0;
    @(posedge clk);
    #2;
    reset = 0;
    if_req_i = 0;
    #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o} !== 2'b00 || dut.starve_cnt !== 4'd0) begin
      errors++; $display("FAIL rmid_during got rv=%b%b starve=%0d exp 00 0",
        if_rvalid_o, ls_rvalid_o, dut.starve_cnt);
    end
    @(negedge clk); reset = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({if_rvalid_o, ls_rvalid_o} !== 2'b00) begin
        errors++; $display("FAIL rmid_after%0d got rv=%b%b exp 00", i, if_rvalid_o, ls_rvalid_o);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ls_req_i = 1; ls_write_i = 0; ls_addr_i = 16'h0040;
    #1;
    checks++;
    if ({ls_gnt_o, mem_addr_o} !== {1'b1, 16'h0040}) begin
      errors++; $display("FAIL b2b_ls_gnt got gnt=%b addr=%h exp 1 0040", ls_gnt_o, mem_addr_o);
    end
    @(negedge clk);
    ls_req_i = 0; if_req_i = 1; if_addr_i = 16'h0044; mem_rdata_i = 32'hAAAA0001;
    #1;
    checks++;
    if ({ls_rvalid_o, if_rvalid_o, ls_rdata_o, if_gnt_o, mem_addr_o} !== {2'b10, 32'hAAAA0001, 1'b1, 16'h0044}) begin
      errors++; $display("FAIL b2b_ls_ret got lsrv=%b ifrv=%b data=%h ifgnt=%b addr=%h exp 1 0 aaaa0001 1 0044",
        ls_rvalid_o, if_rvalid_o, ls_rdata_o, if_gnt_o, mem_addr_o);
    end
    @(negedge clk);
    if_req_i = 0; mem_rdata_i = 32'hBBBB0002;
    #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o, if_rdata_o} !== {2'b10, 32'hBBBB0002}) begin
      errors++; $display("FAIL b2b_if_ret got ifrv=%b lsrv=%b data=%h exp 1 0 bbbb0002",
        if_rvalid_o, ls_rvalid_o, if_rdata_o);
    end
    @(negedge clk); #1;
    checks++;
    if ({if_rvalid_o, ls_rvalid_o} !== 2'b00) begin
      errors++; $display("FAIL b2b_quiet got rv=%b%b exp 00", if_rvalid_o, ls_rvalid_o);
    end
    idle();
  endtask

  task automatic test_drop_request();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_req_i = 1; ls_req_i = 1; ls_write_i = 1;
    end
    @(negedge clk);
    checks++;
    if (dut.starve_cnt !== 4'd3) begin
      errors++; $display("FAIL drop_pre got %0d exp 3", dut.starve_cnt);
    end
    if_req_i = 0;
    @(negedge clk);
    checks++;
    if (dut.starve_cnt !== 4'd0) begin
      errors++; $display("FAIL drop_clear got %0d exp 0", dut.starve_cnt);
    end
    if_req_i = 1;
    #1;
    checks++;
    if ({ls_gnt_o, if_gnt_o} !== 2'b10) begin
      errors++; $display("FAIL drop_prio got ls=%b if=%b exp 1 0", ls_gnt_o, if_gnt_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_conflict();
    test_starvation();
    test_store();
    test_reset_mid();
    test_back_to_back();
    test_drop_request();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
